xmodem_loader: RTL

Receive-side XMODEM (checksum variant) protocol engine between the UART RX path (`uart_top`) and the instruction memory inside `cpu_subsystem`. It consumes received bytes, validates each 128-byte block, and packs payload bytes little-endian into 32-bit instruction words. It writes those words to instruction memory and answers each block with ACK/NAK through the UART TX path. It is the program-load front end of the debug unit; the CPU is enabled only after `o_done`.

---
 rtl/xmodem_pkg.sv | 20 ++
 rtl/xmodem_word_packer.sv | 45 ++++
 rtl/xmodem_loader.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/xmodem_pkg.sv
// Shared XMODEM protocol constants and loader state encoding.
package xmodem_pkg;
    localparam logic [7:0] SOH = 8'h01;
    localparam logic [7:0] EOT = 8'h04;
    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;
    localparam logic [7:0] CAN = 8'h18;

    localparam int BLOCK_BYTES = 128;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BLK,
        ST_BLKN,
        ST_DATA,
        ST_CKSUM,
        ST_RESP,
        ST_DONE
    } state_t;
endpackage

// File: rtl/xmodem_word_packer.sv
// Packs bytes LSB-first into words; word_vld pulses one cycle after the last byte strobe.
// No backpressure: every strobe is consumed, clear restarts the byte count.
module xmodem_word_packer #(
    parameter int NB_BYTE = 8,
    parameter int NB_WORD = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               byte_stb,
    input  logic [NB_BYTE-1:0] byte_dat,
    output logic               word_vld,
    output logic [NB_WORD-1:0] word
);
    localparam int BYTES = NB_WORD / NB_BYTE;
    localparam int CW    = $clog2(BYTES);

    logic [CW-1:0]              cnt;
    logic [NB_WORD-NB_BYTE-1:0] sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            sr       <= '0;
            word_vld <= 1'b0;
            word     <= '0;
        end else begin
            word_vld <= 1'b0;
            if (clear) begin
                cnt <= '0;
                sr  <= '0;
            end else if (byte_stb) begin
                // newest byte enters at the top so the first byte ends up in bits [7:0]
                sr <= {byte_dat, sr[NB_WORD-NB_BYTE-1:NB_BYTE]};
                if (cnt == CW'(BYTES - 1)) begin
                    cnt      <= '0;
                    word     <= {byte_dat, sr};
                    word_vld <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/xmodem_loader.sv
// Receive-side XMODEM (checksum) engine: validates 128-byte blocks, writes packed words to IMEM, answers ACK/NAK.
// Optional inactivity abort is built when XMODEM_TIMEOUT_EN is defined.
module xmodem_loader
    import xmodem_pkg::*;
#(
    parameter int NB_INSTRUCTION  = 32,
    parameter int IMEM_ADDR_WIDTH = 7,
    parameter int NB_UART_DATA    = 8,
    parameter int TIMEOUT_CYCLES  = 50_000_000
) (
    input  logic                       clk,
    input  logic                       i_rst,
    input  logic [NB_UART_DATA-1:0]    i_uart_rx_data,
    input  logic                       i_uart_rx_done,
    output logic                       o_uart_rd,
    output logic [NB_UART_DATA-1:0]    o_uart_wdata,
    output logic                       o_uart_wr,
    output logic                       o_uart_tx_start,
    output logic                       o_imem_we,
    output logic [IMEM_ADDR_WIDTH-1:0] o_imem_addr,
    output logic [NB_INSTRUCTION-1:0]  o_imem_wdata,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_err
);
    state_t                  state;
    logic                    rd;
    logic [NB_UART_DATA-1:0] byte_q;
    logic                    held;
    logic [NB_UART_DATA-1:0] held_byte;
    logic [7:0]              exp_blk;
    logic [7:0]              blk_prev;
    logic [7:0]              blk_q;
    logic [7:0]              cksum;
    logic [6:0]              data_cnt;
    logic                    blk_new;
    logic                    blk_dup;
    logic                    eot_flag;
    logic                    wr;
    logic [NB_UART_DATA-1:0] wdata;
    logic                    busy;
    logic                    err;
    logic                    done;
    logic [4:0]              widx;
    logic                    can_take;
    logic                    pack_clear;
    logic                    pack_stb;
    logic                    word_vld;
    logic [NB_INSTRUCTION-1:0] word;

`ifdef XMODEM_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;
`endif

    // A byte is processed in the cycle its pop is visible; new bytes wait out that cycle and RESP/DONE.
    assign can_take   = (state != ST_RESP) && (state != ST_DONE) && !rd;
    assign pack_clear = rd && (state == ST_IDLE) && (byte_q == SOH);
    assign pack_stb   = rd && (state == ST_DATA);
    assign blk_prev   = exp_blk - 8'd1;

    xmodem_word_packer #(
        .NB_BYTE (NB_UART_DATA),
        .NB_WORD (NB_INSTRUCTION)
    ) u_packer (
        .clk      (clk),
        .rst      (i_rst),
        .clear    (pack_clear),
        .byte_stb (pack_stb),
        .byte_dat (byte_q),
        .word_vld (word_vld),
        .word     (word)
    );

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            rd        <= 1'b0;
            byte_q    <= '0;
            held      <= 1'b0;
            held_byte <= '0;
            exp_blk   <= 8'd1;
            blk_q     <= '0;
            cksum     <= '0;
            data_cnt  <= '0;
            blk_new   <= 1'b0;
            blk_dup   <= 1'b0;
            eot_flag  <= 1'b0;
            wr        <= 1'b0;
            wdata     <= '0;
            busy      <= 1'b0;
            err       <= 1'b0;
            done      <= 1'b0;
            widx      <= '0;
`ifdef XMODEM_TIMEOUT_EN
            to_cnt    <= '0;
`endif
        end else begin
            rd   <= 1'b0;
            wr   <= 1'b0;
            done <= 1'b0;

            if (can_take && held) begin
                rd     <= 1'b1;
                byte_q <= held_byte;
                held   <= i_uart_rx_done;
                if (i_uart_rx_done)
                    held_byte <= i_uart_rx_data;
            end else if (can_take && i_uart_rx_done) begin
                rd     <= 1'b1;
                byte_q <= i_uart_rx_data;
            end else if (i_uart_rx_done) begin
                held      <= 1'b1;
                held_byte <= i_uart_rx_data;
            end

            if (word_vld)
                widx <= widx + 5'd1;

            case (state)
                ST_IDLE: if (rd) begin
                    case (byte_q)
                        SOH: begin
                            state    <= ST_BLK;
                            busy     <= 1'b1;
                            err      <= 1'b0;
                            cksum    <= '0;
                            data_cnt <= '0;
                        end
                        EOT: begin
                            wr       <= 1'b1;
                            wdata    <= ACK;
                            eot_flag <= 1'b1;
                            state    <= ST_RESP;
                        end
                        CAN:     err <= 1'b1;
                        default: ;
                    endcase
                end
                ST_BLK: if (rd) begin
                    blk_q <= byte_q;
                    state <= ST_BLKN;
                end
                ST_BLKN: if (rd) begin
                    blk_new <= (blk_q == exp_blk)  && (byte_q == ~blk_q);
                    blk_dup <= (blk_q == blk_prev) && (byte_q == ~blk_q);
                    widx    <= '0;
                    state   <= ST_DATA;
                end
                ST_DATA: if (rd) begin
                    cksum    <= cksum + byte_q;
                    data_cnt <= data_cnt + 7'd1;
                    if (data_cnt == 7'(BLOCK_BYTES - 1))
                        state <= ST_CKSUM;
                end
                ST_CKSUM: if (rd) begin
                    wr    <= 1'b1;
                    state <= ST_RESP;
                    if ((byte_q == cksum) && (blk_new || blk_dup)) begin
                        wdata <= ACK;
                        if (blk_new)
                            exp_blk <= exp_blk + 8'd1;
                    end else begin
                        wdata <= NAK;
                    end
                end
                ST_RESP: begin
                    busy     <= 1'b0;
                    eot_flag <= 1'b0;
                    done     <= eot_flag;
                    state    <= eot_flag ? ST_DONE : ST_IDLE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase

`ifdef XMODEM_TIMEOUT_EN
            if ((state == ST_BLK) || (state == ST_BLKN) ||
                (state == ST_DATA) || (state == ST_CKSUM)) begin
                if (rd) begin
                    to_cnt <= '0;
                end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    to_cnt <= '0;
                    wr     <= 1'b1;
                    wdata  <= NAK;
                    err    <= 1'b1;
                    state  <= ST_RESP;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end else begin
                to_cnt <= '0;
            end
`endif
        end
    end

    // Write address: block base ((exp_blk-1)*128) plus word offset, wrapped to the IMEM size.
    assign o_imem_we       = word_vld && blk_new;
    assign o_imem_wdata    = word;
    assign o_imem_addr     = IMEM_ADDR_WIDTH'({blk_prev, 7'd0} + {8'd0, widx, 2'b00});
    assign o_uart_rd       = rd;
    assign o_uart_wr       = wr;
    assign o_uart_tx_start = wr;
    assign o_uart_wdata    = wdata;
    assign o_busy          = busy;
    assign o_done          = done;
    assign o_err           = err;
endmodule
